// File: rtl/mips_single_cycle.sv
// rtl/mips_single_cycle.sv - single-cycle 32-bit MIPS subset CPU with internal memories

module mips_bytemem #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem_array [0:DEPTH-1];

    // Byte lanes wrap around the end of the array.
    function automatic logic [AW-1:0] idx(input logic [31:0] a, input int unsigned k);
        return AW'((a + 32'(k)) % 32'(DEPTH));
    endfunction

    assign rdata = {mem_array[idx(addr, 3)], mem_array[idx(addr, 2)],
                    mem_array[idx(addr, 1)], mem_array[idx(addr, 0)]};

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[idx(addr, 0)] <= wdata[7:0];
            mem_array[idx(addr, 1)] <= wdata[15:8];
            mem_array[idx(addr, 2)] <= wdata[23:16];
            mem_array[idx(addr, 3)] <= wdata[31:24];
        end
    end
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] file_array [0:31];

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : file_array[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : file_array[ra2];

    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            file_array[wa] <= wd;
        end
    end
endmodule

module mips_single_cycle #(
    parameter int IMEM_BYTES = 128,
    parameter int DMEM_BYTES = 128
) (
    input logic clk,
    input logic rst
);
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctl_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    logic [31:0] pc, pc_plus4, pc_branch, pc_jump, pc_next;
    logic [31:0] instr, sign_ext, rs_val, rt_val, alu_b, alu_result;
    logic [31:0] dmem_rdata, rfile_wd;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic [15:0] imm;
    logic        alu_zero;

    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump;
    logic [1:0]  alu_op;
    logic        funct_ok;
    alu_ctl_e    alu_ctl;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm    = instr[15:0];
    assign funct  = instr[5:0];

    mips_bytemem #(.DEPTH(IMEM_BYTES)) InstrMem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc),
        .wdata (32'd0),
        .rdata (instr)
    );

    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = 2'b01;
            end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    // Unknown R-type functs fall through as NOPs via funct_ok.
    always_comb begin
        alu_ctl  = ALU_ADD;
        funct_ok = 1'b1;
        case (alu_op)
            2'b01: alu_ctl = ALU_SUB;
            2'b10: begin
                case (funct)
                    6'd32:   alu_ctl = ALU_ADD;
                    6'd34:   alu_ctl = ALU_SUB;
                    6'd36:   alu_ctl = ALU_AND;
                    6'd37:   alu_ctl = ALU_OR;
                    6'd42:   alu_ctl = ALU_SLT;
                    default: funct_ok = 1'b0;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    assign sign_ext = {{16{imm[15]}}, imm};
    assign wa       = reg_dst ? rd : rt;

    mips_regfile RegFile (
        .clk (clk),
        .we  (rst && reg_write && funct_ok),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wa),
        .wd  (rfile_wd),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    assign alu_b = alu_src ? sign_ext : rt_val;

    always_comb begin
        alu_result = 32'd0;
        case (alu_ctl)
            ALU_ADD: alu_result = rs_val + alu_b;
            ALU_SUB: alu_result = rs_val - alu_b;
            ALU_AND: alu_result = rs_val & alu_b;
            ALU_OR:  alu_result = rs_val | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    mips_bytemem #(.DEPTH(DMEM_BYTES)) DatMem (
        .clk   (clk),
        .we    (rst && mem_write),
        .addr  (alu_result),
        .wdata (rt_val),
        .rdata (dmem_rdata)
    );

    assign rfile_wd = mem_to_reg ? dmem_rdata : alu_result;

    assign pc_plus4  = pc + 32'd4;
    assign pc_branch = pc_plus4 + (sign_ext << 2);
    assign pc_jump   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign pc_next   = jump ? pc_jump : ((branch && alu_zero) ? pc_branch : pc_plus4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 32'd0;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_mips_single_cycle.sv
// tb/tb_mips_single_cycle.sv - directed checks for mips_single_cycle

module tb_mips_single_cycle;
    logic clk;
    logic rst;

    int passed = 0;
    int total  = 0;

    mips_single_cycle #(.IMEM_BYTES(128), .DMEM_BYTES(128)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        bit          chk_wd;
        logic [31:0] wd;
        int          r;
        logic [31:0] rv;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] rtype(input int s, input int t, input int d, input int f);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int s, input int t, input logic [15:0] i);
        return {6'(op), 5'(s), 5'(t), i};
    endfunction

    function automatic logic [31:0] jtype(input logic [25:0] tgt);
        return {6'd2, tgt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic imem_word(input int a, input logic [31:0] w);
        dut.InstrMem.mem_array[a]   = w[7:0];
        dut.InstrMem.mem_array[a+1] = w[15:8];
        dut.InstrMem.mem_array[a+2] = w[23:16];
        dut.InstrMem.mem_array[a+3] = w[31:24];
    endtask

    function automatic logic [31:0] dmem_word(input int a);
        return {dut.DatMem.mem_array[a+3], dut.DatMem.mem_array[a+2],
                dut.DatMem.mem_array[a+1], dut.DatMem.mem_array[a]};
    endfunction

    task automatic enter_reset;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) begin
            dut.InstrMem.mem_array[i] = 8'h00;
            dut.DatMem.mem_array[i]   = 8'h00;
        end
        for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = 32'd0;
    endtask

    task automatic release_reset;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_rtype_prog;
        for (int i = 0; i < 12; i++) imem_word(4 * i, vecs[i].instr);
        dut.RegFile.file_array[1]  = 32'd5;
        dut.RegFile.file_array[2]  = 32'd3;
        dut.RegFile.file_array[8]  = 32'h55;
        dut.RegFile.file_array[10] = 32'hFFFF_FFFF;
        dut.RegFile.file_array[12] = 32'h1212_1212;
        dut.RegFile.file_array[13] = 32'h13;
        dut.RegFile.file_array[14] = 32'h14;
    endtask

    initial begin
        rst = 1'b0;
        vecs[0]  = '{"add",      rtype(1, 2, 3, 32),  1, 32'd8,          3,  32'd8};
        vecs[1]  = '{"sub",      rtype(1, 2, 4, 34),  1, 32'd2,          4,  32'd2};
        vecs[2]  = '{"and",      rtype(1, 2, 5, 36),  1, 32'd1,          5,  32'd1};
        vecs[3]  = '{"or",       rtype(1, 2, 6, 37),  1, 32'd7,          6,  32'd7};
        vecs[4]  = '{"slt_t",    rtype(2, 1, 7, 42),  1, 32'd1,          7,  32'd1};
        vecs[5]  = '{"slt_f",    rtype(1, 2, 8, 42),  1, 32'd0,          8,  32'd0};
        vecs[6]  = '{"sub_neg",  rtype(2, 1, 9, 34),  1, 32'hFFFF_FFFE,  9,  32'hFFFF_FFFE};
        vecs[7]  = '{"slt_sgn",  rtype(10, 1, 11, 42), 1, 32'd1,         11, 32'd1};
        vecs[8]  = '{"add_r0",   rtype(1, 2, 0, 32),  1, 32'd8,          0,  32'd0};
        vecs[9]  = '{"funct0",   rtype(1, 2, 12, 0),  0, 32'd0,          12, 32'h1212_1212};
        vecs[10] = '{"funct39",  rtype(1, 2, 13, 39), 0, 32'd0,          13, 32'h13};
        vecs[11] = '{"op_addi",  itype(8, 1, 14, 16'h7), 0, 32'd0,       14, 32'h14};

        // Reset hold: register and memory writes suppressed, pc pinned at 0.
        enter_reset;
        imem_word(0, rtype(1, 2, 3, 32));
        imem_word(4, itype(43, 0, 1, 16'd8));
        dut.RegFile.file_array[1] = 32'd5;
        dut.RegFile.file_array[2] = 32'd3;
        dut.RegFile.file_array[3] = 32'h0BAD;
        step;
        step;
        check("rst_pc", dut.pc, 32'd0);
        check("rst_reg", dut.RegFile.file_array[3], 32'h0BAD);
        imem_word(0, itype(43, 0, 1, 16'd8));
        step;
        step;
        check("rst_mem", dmem_word(8), 32'd0);
        imem_word(0, rtype(1, 2, 3, 32));
        release_reset;
        check("rel_pc0", dut.pc, 32'd0);
        step;
        check("rel_pc4", dut.pc, 32'd4);
        check("rel_reg", dut.RegFile.file_array[3], 32'd8);
        step;
        check("rel_sw", dmem_word(8), 32'd5);

        // R-type and NOP table.
        enter_reset;
        load_rtype_prog;
        release_reset;
        for (int i = 0; i < 12; i++) begin
            check({vecs[i].name, "_pc"}, dut.pc, 32'(4 * i));
            if (vecs[i].chk_wd) check({vecs[i].name, "_wd"}, dut.rfile_wd, vecs[i].wd);
            step;
            check({vecs[i].name, "_reg"}, dut.RegFile.file_array[vecs[i].r], vecs[i].rv);
        end

        // LW then SW.
        enter_reset;
        imem_word(0, itype(35, 1, 2, 16'd0));
        imem_word(4, itype(43, 1, 2, 16'd8));
        dut.DatMem.mem_array[0] = 8'h78;
        dut.DatMem.mem_array[1] = 8'h56;
        dut.DatMem.mem_array[2] = 8'h34;
        dut.DatMem.mem_array[3] = 8'h12;
        release_reset;
        check("lw_wd", dut.rfile_wd, 32'h1234_5678);
        step;
        check("lw_reg", dut.RegFile.file_array[2], 32'h1234_5678);
        step;
        check("sw_b8", 32'(dut.DatMem.mem_array[8]), 32'h78);
        check("sw_word", dmem_word(8), 32'h1234_5678);

        // BEQ taken forward, then backward via beq $0,$0,-4.
        enter_reset;
        imem_word(0, jtype(26'd4));
        imem_word(32'h10, itype(4, 1, 2, 16'd2));
        imem_word(32'h1C, itype(4, 0, 0, 16'hFFFC));
        dut.RegFile.file_array[1] = 32'd7;
        dut.RegFile.file_array[2] = 32'd7;
        release_reset;
        step;
        check("j_to_10", dut.pc, 32'h10);
        step;
        check("beq_taken", dut.pc, 32'h1C);
        step;
        check("beq_back", dut.pc, 32'h10);

        // BEQ not taken.
        enter_reset;
        imem_word(0, jtype(26'd4));
        imem_word(32'h10, itype(4, 1, 2, 16'd2));
        dut.RegFile.file_array[1] = 32'd7;
        dut.RegFile.file_array[2] = 32'd8;
        release_reset;
        step;
        step;
        check("beq_not", dut.pc, 32'h14);

        // J loop.
        enter_reset;
        imem_word(0, jtype(26'd8));
        imem_word(32'h20, jtype(26'd0));
        release_reset;
        step;
        check("j_to_20", dut.pc, 32'h20);
        step;
        check("j_to_0", dut.pc, 32'h0);

        // Asynchronous reset between edges.
        enter_reset;
        load_rtype_prog;
        release_reset;
        step;
        step;
        step;
        check("run_pc", dut.pc, 32'd12);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_pc", dut.pc, 32'd0);
        check("async_r3", dut.RegFile.file_array[3], 32'd8);
        check("async_r6", dut.RegFile.file_array[6], 32'd7);
        release_reset;
        check("restart_pc0", dut.pc, 32'd0);
        step;
        check("restart_pc4", dut.pc, 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
